// File: rtl/vga_scene_renderer.sv
// -----------------------------------------------------------------------------
// vga_scene_renderer
//
// Parametrised VGA timing generator and scene renderer. It draws a border,
// PADDLE_COUNT paddles and one ball over a selectable background. Object
// positions are double-buffered: posWrite fills a shadow set, and the shadow
// set is copied into the live set at the start of the first blanking line,
// so a picture never tears mid-frame.
//
// Pipeline: stage 0 = counters + combinational decode, stage 1 = hit flags
// and delayed timing, stage 2 = colour select and registered outputs.
// Every output is therefore exactly two cycles behind the counters.
//
// Optional feature macro: VGA_CHECKER_BG_EN
//   defined   -> 32x32 checkerboard background (full / half intensity)
//   undefined -> solid background colour
//
// Ports:
//   pixelClock  pixel clock, the only clock
//   resetN      synchronous active-low reset
//   paddleY     top Y of each paddle, paddle i in bits [10i+9:10i]
//   ballX/ballY ball top-left corner
//   posWrite    captures paddleY/ballX/ballY into the shadow set
//   bgColor     background {b,g,r}, each bit widened to a full channel
//   rColor/gColor/bColor  8-bit colour channels
//   hSync/vSync active-low syncs, blankN high in the active area
//   syncN       tied low
//   frameStart  one-cycle pulse aligned with the live-set load
//   xPixel/yPixel coordinates of the pixel currently on the outputs
// -----------------------------------------------------------------------------
module vga_scene_renderer #(
    parameter int          H_VISIBLE    = 1024,
    parameter int          H_FRONT      = 24,
    parameter int          H_SYNC       = 136,
    parameter int          H_BACK       = 160,
    parameter int          V_VISIBLE    = 768,
    parameter int          V_FRONT      = 3,
    parameter int          V_SYNC       = 6,
    parameter int          V_BACK       = 29,
    parameter int          BORDER       = 16,
    parameter int          PADDLE_COUNT = 2,
    parameter int          PADDLE_W     = 16,
    parameter int          PADDLE_H     = 96,
    parameter int          PADDLE_GAP   = 16,
    parameter int          BALL_SIZE    = 16,
    parameter logic [23:0] BORDER_COLOR = 24'h00FFFF,
    parameter logic [23:0] PADDLE_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BALL_COLOR   = 24'hFFFF00
) (
    input  logic                       pixelClock,
    input  logic                       resetN,
    input  logic [PADDLE_COUNT*10-1:0] paddleY,
    input  logic [10:0]                ballX,
    input  logic [9:0]                 ballY,
    input  logic                       posWrite,
    input  logic [2:0]                 bgColor,
    output logic [7:0]                 rColor,
    output logic [7:0]                 gColor,
    output logic [7:0]                 bColor,
    output logic                       hSync,
    output logic                       vSync,
    output logic                       blankN,
    output logic                       syncN,
    output logic                       frameStart,
    output logic [10:0]                xPixel,
    output logic [9:0]                 yPixel
);

    localparam logic [10:0] H_LAST        = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_LAST        = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] HS_FIRST      = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST       = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST      = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [10:0] H_ACT         = 11'(H_VISIBLE);
    localparam logic [9:0]  V_ACT         = 10'(V_VISIBLE);
    // Geometry is compared at 12 bits so ball/paddle right edges never wrap.
    localparam logic [11:0] BORDER_W      = 12'(BORDER);
    localparam logic [11:0] BORDER_RIGHT  = 12'(H_VISIBLE - BORDER);
    localparam logic [11:0] BORDER_BOTTOM = 12'(V_VISIBLE - BORDER);
    localparam logic [11:0] PAD0_LEFT     = 12'(H_VISIBLE - BORDER - PADDLE_GAP - PADDLE_W);
    localparam logic [11:0] PAD1_LEFT     = 12'(BORDER + PADDLE_GAP);
    localparam logic [11:0] PAD_WIDTH     = 12'(PADDLE_W);
    localparam logic [11:0] PAD_HEIGHT    = 12'(PADDLE_H);
    localparam logic [11:0] BALL_SPAN     = 12'(BALL_SIZE);
    localparam logic [9:0]  PAD_MIN       = 10'(BORDER);
    localparam logic [9:0]  PAD_MAX       = 10'(V_VISIBLE - BORDER - PADDLE_H);
    localparam logic [9:0]  PAD_RESET     = 10'((V_VISIBLE - PADDLE_H) / 2);
    localparam logic [10:0] BALL_X_RESET  = 11'((H_VISIBLE - BALL_SIZE) / 2);
    localparam logic [9:0]  BALL_Y_RESET  = 10'((V_VISIBLE - BALL_SIZE) / 2);

    // Half-open interval test [start, start+len).
    function automatic logic inSpan(input logic [11:0] pos, input logic [11:0] start,
                                    input logic [11:0] len);
        return (pos >= start) && (pos < start + len);
    endfunction

    // Keep paddles inside the playfield between the top and bottom borders.
    function automatic logic [9:0] clampPad(input logic [9:0] y);
        if (y < PAD_MIN) begin
            return PAD_MIN;
        end else if (y > PAD_MAX) begin
            return PAD_MAX;
        end else begin
            return y;
        end
    endfunction

    logic [10:0]                   hCount_r;
    logic [9:0]                    vCount_r;
    logic [PADDLE_COUNT-1:0][9:0]  shadowPad_r;
    logic [PADDLE_COUNT-1:0][9:0]  activePad_r;
    logic [10:0]                   shadowBallX_r;
    logic [10:0]                   activeBallX_r;
    logic [9:0]                    shadowBallY_r;
    logic [9:0]                    activeBallY_r;

    logic [11:0]                   xWide_s;
    logic [11:0]                   yWide_s;
    logic                          loadFrame_s;
    logic                          hSync_s;
    logic                          vSync_s;
    logic                          active_s;
    logic                          borderHit_s;
    logic                          ballHit_s;
    logic [PADDLE_COUNT-1:0]       paddleHit_s;

    logic                          borderHit_r;
    logic                          ballHit_r;
    logic [PADDLE_COUNT-1:0]       paddleHit_r;
    logic                          hSync1_r;
    logic                          vSync1_r;
    logic                          active1_r;
    logic                          frameStart1_r;
    logic [10:0]                   x1_r;
    logic [9:0]                    y1_r;
    logic [2:0]                    bgColor1_r;

    logic [23:0]                   bgFull_s;
    logic [23:0]                   bgPix_s;
    logic [23:0]                   color_s;

    // Horizontal/vertical position counters.
    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            hCount_r <= 11'd0;
            vCount_r <= 10'd0;
        end else if (hCount_r == H_LAST) begin
            hCount_r <= 11'd0;
            if (vCount_r == V_LAST) begin
                vCount_r <= 10'd0;
            end else begin
                vCount_r <= vCount_r + 10'd1;
            end
        end else begin
            hCount_r <= hCount_r + 11'd1;
        end
    end

    // Stage 0: timing decode and object hit tests against the live set.
    always_comb begin
        xWide_s     = {1'b0, hCount_r};
        yWide_s     = {2'b00, vCount_r};
        loadFrame_s = (hCount_r == 11'd0) && (vCount_r == V_ACT);
        hSync_s     = !((hCount_r >= HS_FIRST) && (hCount_r <= HS_LAST));
        vSync_s     = !((vCount_r >= VS_FIRST) && (vCount_r <= VS_LAST));
        active_s    = (hCount_r < H_ACT) && (vCount_r < V_ACT);
        borderHit_s = (xWide_s < BORDER_W) || (xWide_s >= BORDER_RIGHT) ||
                      (yWide_s < BORDER_W) || (yWide_s >= BORDER_BOTTOM);
        ballHit_s   = inSpan(xWide_s, {1'b0, activeBallX_r}, BALL_SPAN) &&
                      inSpan(yWide_s, {2'b00, activeBallY_r}, BALL_SPAN);
        paddleHit_s = {PADDLE_COUNT{1'b0}};
        // Paddle 0 sits on the right, paddle 1 on the left.
        for (int i = 0; i < PADDLE_COUNT; i++) begin
            paddleHit_s[i] = inSpan(xWide_s, (i == 0) ? PAD0_LEFT : PAD1_LEFT, PAD_WIDTH) &&
                             inSpan(yWide_s, {2'b00, activePad_r[i]}, PAD_HEIGHT);
        end
    end

    // Shadow capture and frame-boundary load of the live position set.
    // On a coincident write the load takes the old shadow value.
    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            for (int i = 0; i < PADDLE_COUNT; i++) begin
                shadowPad_r[i] <= PAD_RESET;
                activePad_r[i] <= PAD_RESET;
            end
            shadowBallX_r <= BALL_X_RESET;
            activeBallX_r <= BALL_X_RESET;
            shadowBallY_r <= BALL_Y_RESET;
            activeBallY_r <= BALL_Y_RESET;
        end else begin
            if (loadFrame_s) begin
                for (int i = 0; i < PADDLE_COUNT; i++) begin
                    activePad_r[i] <= clampPad(shadowPad_r[i]);
                end
                activeBallX_r <= shadowBallX_r;
                activeBallY_r <= shadowBallY_r;
            end
            if (posWrite) begin
                for (int i = 0; i < PADDLE_COUNT; i++) begin
                    shadowPad_r[i] <= paddleY[10*i +: 10];
                end
                shadowBallX_r <= ballX;
                shadowBallY_r <= ballY;
            end
        end
    end

    // Stage 1: register hit flags and the timing that travels with them.
    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            borderHit_r   <= 1'b0;
            ballHit_r     <= 1'b0;
            paddleHit_r   <= {PADDLE_COUNT{1'b0}};
            hSync1_r      <= 1'b1;
            vSync1_r      <= 1'b1;
            active1_r     <= 1'b0;
            frameStart1_r <= 1'b0;
            x1_r          <= 11'd0;
            y1_r          <= 10'd0;
            bgColor1_r    <= 3'd0;
        end else begin
            borderHit_r   <= borderHit_s;
            ballHit_r     <= ballHit_s;
            paddleHit_r   <= paddleHit_s;
            hSync1_r      <= hSync_s;
            vSync1_r      <= vSync_s;
            active1_r     <= active_s;
            frameStart1_r <= loadFrame_s;
            x1_r          <= hCount_r;
            y1_r          <= vCount_r;
            bgColor1_r    <= bgColor;
        end
    end

    // Stage 2 colour select: ball > paddle > border > background.
    always_comb begin
        bgFull_s = {{8{bgColor1_r[0]}}, {8{bgColor1_r[1]}}, {8{bgColor1_r[2]}}};
`ifdef VGA_CHECKER_BG_EN
        if (x1_r[5] ^ y1_r[5]) begin
            bgPix_s = bgFull_s;
        end else begin
            bgPix_s = {1'b0, bgFull_s[23:17], 1'b0, bgFull_s[15:9], 1'b0, bgFull_s[7:1]};
        end
`else
        bgPix_s = bgFull_s;
`endif
        if (!active1_r) begin
            color_s = 24'h000000;
        end else if (ballHit_r) begin
            color_s = BALL_COLOR;
        end else if (|paddleHit_r) begin
            color_s = PADDLE_COLOR;
        end else if (borderHit_r) begin
            color_s = BORDER_COLOR;
        end else begin
            color_s = bgPix_s;
        end
    end

    // Stage 2: registered outputs, all mutually aligned.
    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            rColor     <= 8'd0;
            gColor     <= 8'd0;
            bColor     <= 8'd0;
            hSync      <= 1'b1;
            vSync      <= 1'b1;
            blankN     <= 1'b0;
            syncN      <= 1'b0;
            frameStart <= 1'b0;
            xPixel     <= 11'd0;
            yPixel     <= 10'd0;
        end else begin
            rColor     <= color_s[23:16];
            gColor     <= color_s[15:8];
            bColor     <= color_s[7:0];
            hSync      <= hSync1_r;
            vSync      <= vSync1_r;
            blankN     <= active1_r;
            syncN      <= 1'b0;
            frameStart <= frameStart1_r;
            xPixel     <= x1_r;
            yPixel     <= y1_r;
        end
    end

endmodule

// File: tb/tb_vga_scene_renderer.sv
// -----------------------------------------------------------------------------
// tb_vga_scene_renderer
//
// Drives a reduced-resolution instance of vga_scene_renderer and compares
// every output pixel against a scene model that evaluates the drawing rules
// directly from screen coordinates and the object positions it has seen
// written. Also checks sync periods/widths and a few fixed pixels.
// -----------------------------------------------------------------------------
module tb_vga_scene_renderer;

    localparam int HV  = 64;
    localparam int HF  = 4;
    localparam int HS  = 8;
    localparam int HB  = 8;
    localparam int VV  = 48;
    localparam int VF  = 2;
    localparam int VS  = 3;
    localparam int VB  = 3;
    localparam int HT  = HV + HF + HS + HB;
    localparam int VT  = VV + VF + VS + VB;
    localparam int BRD = 4;
    localparam int PC  = 2;
    localparam int PW  = 4;
    localparam int PH  = 12;
    localparam int PG  = 4;
    localparam int BS  = 6;
    localparam logic [49:0] RESET_VEC = {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 10'd0};

    logic             pixelClock;
    logic             resetN;
    logic [PC*10-1:0] paddleY;
    logic [10:0]      ballX;
    logic [9:0]       ballY;
    logic             posWrite;
    logic [2:0]       bgColor;
    logic [7:0]       rColor;
    logic [7:0]       gColor;
    logic [7:0]       bColor;
    logic             hSync;
    logic             vSync;
    logic             blankN;
    logic             syncN;
    logic             frameStart;
    logic [10:0]      xPixel;
    logic [9:0]       yPixel;

    vga_scene_renderer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .BORDER(BRD), .PADDLE_COUNT(PC), .PADDLE_W(PW), .PADDLE_H(PH),
        .PADDLE_GAP(PG), .BALL_SIZE(BS)
    ) dut (
        .pixelClock(pixelClock), .resetN(resetN), .paddleY(paddleY),
        .ballX(ballX), .ballY(ballY), .posWrite(posWrite), .bgColor(bgColor),
        .rColor(rColor), .gColor(gColor), .bColor(bColor),
        .hSync(hSync), .vSync(vSync), .blankN(blankN), .syncN(syncN),
        .frameStart(frameStart), .xPixel(xPixel), .yPixel(yPixel)
    );

    initial pixelClock = 1'b0;
    always #5 pixelClock = ~pixelClock;

    int          compared;
    int          mismatched;
    int          hPos, vPos;
    int          mPad [PC];
    int          sPad [PC];
    int          mBallX, mBallY, sBallX, sBallY;
    logic [49:0] prevExp;
    int          prevH, prevV;
    bit          directedFrame;
    int          edgesSinceRel, lastHFall, lastVFall;
    bit          firstHSeen;
    logic        prevHs, prevVs;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampPad(input int y);
        if (y < BRD) return BRD;
        if (y > VV - BRD - PH) return VV - BRD - PH;
        return y;
    endfunction

    // What the screen should show at (h,v) given the live object set.
    function automatic logic [49:0] expectedOut(input int h, input int v);
        logic [23:0] rgb;
        logic [23:0] full;
        bit          act, onPaddle, onBall, onBorder, hs, vs, fs;
        int          left, r8, g8, b8;
        act      = (h < HV) && (v < VV);
        onPaddle = 1'b0;
        for (int i = 0; i < PC; i++) begin
            left = (i == 0) ? HV - BRD - PG - PW : BRD + PG;
            if (h >= left && h < left + PW && v >= mPad[i] && v < mPad[i] + PH) onPaddle = 1'b1;
        end
        onBall   = (h >= mBallX) && (h < mBallX + BS) && (v >= mBallY) && (v < mBallY + BS);
        onBorder = (h < BRD) || (h >= HV - BRD) || (v < BRD) || (v >= VV - BRD);
        r8 = bgColor[0] ? 255 : 0;
        g8 = bgColor[1] ? 255 : 0;
        b8 = bgColor[2] ? 255 : 0;
`ifdef VGA_CHECKER_BG_EN
        if ((((h / 32) % 2) ^ ((v / 32) % 2)) == 0) begin
            r8 = r8 / 2;
            g8 = g8 / 2;
            b8 = b8 / 2;
        end
`endif
        full = {8'(r8), 8'(g8), 8'(b8)};
        if (!act)          rgb = 24'h000000;
        else if (onBall)   rgb = 24'hFFFF00;
        else if (onPaddle) rgb = 24'hFFFFFF;
        else if (onBorder) rgb = 24'h00FFFF;
        else               rgb = full;
        hs = !(h >= HV + HF && h < HV + HF + HS);
        vs = !(v >= VV + VF && v < VV + VF + VS);
        fs = (h == 0) && (v == VV);
        return {rgb, hs, vs, act, 1'b0, fs, 11'(h), 10'(v)};
    endfunction

    task automatic modelReset();
        hPos = 0;
        vPos = 0;
        for (int i = 0; i < PC; i++) begin
            sPad[i] = (VV - PH) / 2;
            mPad[i] = (VV - PH) / 2;
        end
        sBallX = (HV - BS) / 2;
        mBallX = sBallX;
        sBallY = (VV - BS) / 2;
        mBallY = sBallY;
    endtask

    // One clock: advance the model, clock the DUT, compare.
    task automatic step();
        logic [49:0] e;
        logic [49:0] obs;
        int          eh, ev;
        if (!resetN) begin
            modelReset();
            e       = RESET_VEC;
            eh      = -1;
            ev      = -1;
            prevExp = RESET_VEC;
            prevH   = -1;
            prevV   = -1;
        end else begin
            e  = expectedOut(hPos, vPos);
            eh = hPos;
            ev = vPos;
            if (hPos == 0 && vPos == VV) begin
                for (int i = 0; i < PC; i++) mPad[i] = clampPad(sPad[i]);
                mBallX = sBallX;
                mBallY = sBallY;
            end
            if (posWrite) begin
                for (int i = 0; i < PC; i++) sPad[i] = int'(paddleY[10*i +: 10]);
                sBallX = int'(ballX);
                sBallY = int'(ballY);
            end
            hPos++;
            if (hPos == HT) begin
                hPos = 0;
                vPos++;
                if (vPos == VT) vPos = 0;
            end
        end
        @(posedge pixelClock);
        #1;
        obs = {rColor, gColor, bColor, hSync, vSync, blankN, syncN, frameStart, xPixel, yPixel};
        checkValue("pixel", obs, prevExp);
        if (directedFrame) begin
            if (prevH == 0 && prevV == 0)           checkValue("px_0_0", obs[49:26], 24'h00FFFF);
            if (prevH == HV - 1 && prevV == VV - 1) checkValue("px_last", obs[49:26], 24'h00FFFF);
            if (prevH == 20 && prevV == 20)         checkValue("px_bg", obs[49:26], 24'h000000);
            if (prevH == 30 && prevV == 22)         checkValue("px_ball", obs[49:26], 24'hFFFF00);
            if (prevH == 8 && prevV == 20)          checkValue("px_paddle1", obs[49:26], 24'hFFFFFF);
        end
        if (!resetN) begin
            edgesSinceRel = 0;
            lastHFall     = -1;
            lastVFall     = -1;
            firstHSeen    = 1'b0;
            prevHs        = 1'b1;
            prevVs        = 1'b1;
        end else begin
            edgesSinceRel++;
            if (prevHs && !hSync) begin
                if (!firstHSeen) checkValue("first_hfall", edgesSinceRel, HV + HF + 2);
                else             checkValue("hsync_period", edgesSinceRel - lastHFall, HT);
                firstHSeen = 1'b1;
                lastHFall  = edgesSinceRel;
            end
            if (!prevHs && hSync && lastHFall >= 0) checkValue("hsync_low", edgesSinceRel - lastHFall, HS);
            if (prevVs && !vSync) begin
                if (lastVFall >= 0) checkValue("vsync_period", edgesSinceRel - lastVFall, HT * VT);
                lastVFall = edgesSinceRel;
            end
            if (!prevVs && vSync && lastVFall >= 0) checkValue("vsync_low", edgesSinceRel - lastVFall, VS * HT);
            prevHs = hSync;
            prevVs = vSync;
        end
        prevExp = e;
        prevH   = eh;
        prevV   = ev;
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic runUntil(input int h, input int v);
        int n;
        n = 0;
        while (!(hPos == h && vPos == v) && n < HT * VT + 4) begin
            step();
            n++;
        end
        checkValue("wait_bound", 64'(hPos == h && vPos == v), 64'd1);
    endtask

    // Move to the next load point (crossing the current one if sitting on it).
    task automatic runFrame();
        if (hPos == 0 && vPos == VV) step();
        runUntil(0, VV);
    endtask

    task automatic writePos(input int p0, input int p1, input int bx, input int by);
        paddleY  = {10'(p1), 10'(p0)};
        ballX    = 11'(bx);
        ballY    = 10'(by);
        posWrite = 1'b1;
        step();
        posWrite = 1'b0;
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        resetN        = 1'b0;
        posWrite      = 1'b0;
        paddleY       = {(PC*10){1'b0}};
        ballX         = 11'd0;
        ballY         = 10'd0;
        bgColor       = 3'b000;
        prevExp       = RESET_VEC;
        prevH         = -1;
        prevV         = -1;
        directedFrame = 1'b0;
        edgesSinceRel = 0;
        lastHFall     = -1;
        lastVFall     = -1;
        firstHSeen    = 1'b0;
        prevHs        = 1'b1;
        prevVs        = 1'b1;
        modelReset();

        repeat (3) step();
        resetN = 1'b1;

        // First frame with reset positions and black background.
        directedFrame = 1'b1;
        runUntil(0, VV);
        directedFrame = 1'b0;

        // Mid-frame write: must not appear before the next load.
        runUntil(10, 20);
        writePos(20, 10, 29, 21);
        runFrame();
        runFrame();

        // Clamped right paddle with the ball overlapping it, coloured background.
        runCycles(100);
        bgColor = 3'b101;
        writePos(1000, 0, 52, 30);
        runFrame();
        runFrame();

        // Ball partly beyond the right edge, then a write on the load cycle.
        runCycles(5);
        writePos(30, 30, 60, 40);
        runFrame();
        writePos(5, 40, 2040, 10);
        runFrame();
        runFrame();

        // Random positions and background changes.
        for (int c = 0; c < 3 * HT * VT; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                paddleY  = {10'($urandom_range(0, 63)), 10'($urandom_range(0, 1023))};
                ballX    = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                       : 11'($urandom_range(0, 70));
                ballY    = 10'($urandom_range(0, 55));
                posWrite = 1'b1;
            end else begin
                posWrite = 1'b0;
            end
            if (hPos == 0 && $urandom_range(0, 7) == 0) bgColor = 3'($urandom_range(0, 7));
            step();
        end
        posWrite = 1'b0;

        // Reset in the middle of a frame, then restart timing.
        runUntil(0, 20);
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        runCycles(3 * HT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
